// File: rtl/pds_port_arbiter_pkg.sv
// Shared types and constants for the pds output-port arbiter.
// Also holds the saturating length counter helper.
package pds_arb_pkg;

    typedef enum logic {ARB_RR = 1'b0, ARB_SGLE = 1'b1} arb_policy_e;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

    localparam int PKT_LEN_MAX = 255;

    // Increment that sticks at PKT_LEN_MAX instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'(PKT_LEN_MAX)) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pds_port_arbiter_if.sv
// Bundle of input-port, output-port, policy and status signals of the arbiter.
// master = traffic source/sink side, slave = arbiter side.
interface pds_arb_if #(
    parameter int NPORTS = 4,
    parameter int DW     = 8,
    parameter int PW     = $clog2(NPORTS)
) ();

    logic                 policy;
    logic [PW-1:0]        cfg_port;
    logic [NPORTS-1:0]    in_valid;
    logic [NPORTS-1:0]    in_last;
    logic [NPORTS*DW-1:0] in_data;
    logic [NPORTS-1:0]    in_ready;
    logic                 out_valid;
    logic                 out_last;
    logic [DW-1:0]        out_data;
    logic [PW-1:0]        out_port;
    logic                 out_ready;
    logic                 pkt_done;
    logic [7:0]           pkt_len;

    modport master (
        output policy, cfg_port, in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data, out_port, pkt_done, pkt_len
    );

    modport slave (
        input  policy, cfg_port, in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data, out_port, pkt_done, pkt_len
    );

endinterface

// File: rtl/pds_port_arbiter_chk.sv
// Protocol checker for the arbiter: at most one in_ready, and output beat
// frozen while stalled.
module pds_arb_chk #(
    parameter int NPORTS = 4,
    parameter int DW     = 8,
    parameter int PW     = $clog2(NPORTS)
) (
    input logic              clock,
    input logic              reset,
    input logic [NPORTS-1:0] in_ready,
    input logic              out_valid,
    input logic              out_ready,
    input logic              out_last,
    input logic [DW-1:0]     out_data,
    input logic [PW-1:0]     out_port
);

    a_one_ready: assert property (@(posedge clock) disable iff (reset) $onehot0(in_ready))
        else $error("one_ready violated");

    a_stall_hold: assert property (@(posedge clock) disable iff (reset)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_port) && $stable(out_last)))
        else $error("stall_hold violated");

endmodule

// File: rtl/pds_port_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first requester after 'last',
// wrapping modulo NPORTS.
module pds_rr_pick #(
    parameter int NPORTS = 4,
    parameter int PW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [PW-1:0]     last,
    output logic [PW-1:0]     gnt_idx,
    output logic              any
);

    int   dist_s;
    int   best_s;
    logic take_s;

    // Pick the requester with the smallest rotated distance from last+1.
    always_comb begin
        dist_s  = 0;
        best_s  = NPORTS;
        take_s  = 1'b0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int j = 0; j < NPORTS; j++) begin
            dist_s  = (j + NPORTS - 1 - int'(last)) % NPORTS;
            take_s  = req[j] && (dist_s < best_s);
            best_s  = take_s ? dist_s : best_s;
            gnt_idx = take_s ? PW'(j) : gnt_idx;
            any     = any | req[j];
        end
    end

endmodule

// File: rtl/pds_port_arbiter.sv
// Packet-granular arbiter: grants one input port per packet, holds the grant
// until the last beat is accepted, and forwards beats through a register stage.
module pds_port_arbiter
    import pds_arb_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int DW     = 8,
    parameter int PW     = $clog2(NPORTS)
) (
    input  logic     clock,
    input  logic     reset,
    pds_arb_if.slave bus
);

    arb_state_e        state_r;
    logic [PW-1:0]     grant_r;
    logic [PW-1:0]     rr_last_r;
    logic [7:0]        count_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [DW-1:0]     out_data_r;
    logic [PW-1:0]     out_port_r;
    logic              pkt_done_r;
    logic [7:0]        pkt_len_r;

    arb_policy_e       policy_s;
    logic              cfg_ok_s;
    logic [NPORTS-1:0] elig_s;
    logic [PW-1:0]     pick_idx_s;
    logic              pick_any_s;
    logic              hit_s;
    logic              sel_valid_s;
    logic              sel_last_s;
    logic [DW-1:0]     sel_data_s;
    logic              load_ok_s;
    logic              accept_s;
    logic [NPORTS-1:0] in_ready_s;

    // Eligible requesters for the next arbitration, per current policy.
    always_comb begin
        policy_s = arb_policy_e'(bus.policy);
        cfg_ok_s = (32'(bus.cfg_port) < 32'(NPORTS));
        elig_s   = '0;
        if (policy_s == ARB_RR) begin
            elig_s = bus.in_valid;
        end else if (cfg_ok_s) begin
            elig_s = bus.in_valid & (NPORTS'(1'b1) << bus.cfg_port);
        end else begin
            elig_s = '0;
        end
    end

    pds_rr_pick #(
        .NPORTS (NPORTS),
        .PW     (PW)
    ) u_pick (
        .req     (elig_s),
        .last    (rr_last_r),
        .gnt_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    // Select the granted port's beat.
    always_comb begin
        hit_s       = 1'b0;
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            hit_s       = (grant_r == PW'(i));
            sel_valid_s = sel_valid_s | (hit_s & bus.in_valid[i]);
            sel_last_s  = sel_last_s  | (hit_s & bus.in_last[i]);
            sel_data_s  = hit_s ? bus.in_data[i*DW +: DW] : sel_data_s;
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign load_ok_s  = !out_valid_r || bus.out_ready;
    assign accept_s   = (state_r == BUSY) && load_ok_s && sel_valid_s;
    assign in_ready_s = ((state_r == BUSY) && load_ok_s) ? (NPORTS'(1'b1) << grant_r)
                                                         : {NPORTS{1'b0}};

    // Arbitration FSM, beat counter and registered output stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            rr_last_r   <= PW'(NPORTS - 1);
            count_r     <= 8'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            out_port_r  <= '0;
            pkt_done_r  <= 1'b0;
            pkt_len_r   <= 8'd0;
        end else begin
            pkt_done_r <= 1'b0;

            if (accept_s) begin
                out_valid_r <= 1'b1;
                out_last_r  <= sel_last_s;
                out_data_r  <= sel_data_s;
                out_port_r  <= grant_r;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end

            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        grant_r <= pick_idx_s;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (accept_s && sel_last_s) begin
                        pkt_done_r <= 1'b1;
                        pkt_len_r  <= sat_inc8(count_r);
                        count_r    <= 8'd0;
                        rr_last_r  <= grant_r;
                        state_r    <= IDLE;
                    end else if (accept_s) begin
                        count_r <= sat_inc8(count_r);
                    end else begin
                        state_r <= BUSY;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_port  = out_port_r;
    assign bus.pkt_done  = pkt_done_r;
    assign bus.pkt_len   = pkt_len_r;

endmodule

// File: tb/tb_pds_port_arbiter.sv
// Directed self-checking bench for pds_port_arbiter (NPORTS=4, DW=8, PW=3 so
// that an out-of-range cfg_port can be driven).
module tb_pds_port_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   len;

    always #5 clock = ~clock;

    pds_arb_if #(.NPORTS(4), .DW(8), .PW(3)) bus ();

    pds_port_arbiter #(.NPORTS(4), .DW(8), .PW(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    pds_arb_chk #(.NPORTS(4), .DW(8), .PW(3)) u_chk (
        .clock     (clock),
        .reset     (reset),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_last  (bus.out_last),
        .out_data  (bus.out_data),
        .out_port  (bus.out_port)
    );

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] dat;
        logic [3:0]  rdy;
        logic        ov;
        logic [7:0]  od;
        logic [2:0]  op;
        logic        ol;
        logic        done;
        logic [7:0]  len;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Source one packet on port p, optionally stall the sink, keep 'other'
    // ports requesting as bystanders, and switch to single-lock on cfg_port 0
    // once sw_at beats have been accepted.
    task automatic drive_pkt(input int p, input int n, input logic [7:0] base,
                             input int stall_at, input int stall_len,
                             input logic [3:0] other, input int sw_at,
                             output int got_len);
        int sent = 0, rcvd = 0, cyc = 0, stall = 0, dones = 0;
        logic acc, fire;
        logic [7:0] eb;
        got_len = -1;
        while (rcvd < n && cyc < 2000) begin
            @(negedge clock);
            cyc++;
            bus.in_valid = other;
            bus.in_last  = other;
            bus.in_data  = {4{8'hEE}};
            if (sent < n) begin
                bus.in_valid[p]        = 1'b1;
                bus.in_last[p]         = (sent == n - 1);
                bus.in_data[p*8 +: 8]  = base + 8'(sent);
            end
            if (sent == sw_at) begin
                bus.policy   = 1'b1;
                bus.cfg_port = 3'd0;
            end
            bus.out_ready = !(rcvd >= stall_at && stall < stall_len);
            #1;
            eb   = base + 8'(rcvd);
            acc  = bus.in_valid[p] & bus.in_ready[p];
            fire = bus.out_valid & bus.out_ready;
            if (other != 4'b0000) chk("bystander_rdy", bus.in_ready & other, 32'd0);
            if (bus.out_valid && !bus.out_ready) begin
                chk("stall_rdy", bus.in_ready[p], 32'd0);
                chk("stall_data", bus.out_data, eb);
            end
            if (fire) begin
                chk("beat_data", bus.out_data, eb);
                chk("beat_port", bus.out_port, p);
                chk("beat_last", bus.out_last, (rcvd == n - 1));
            end
            if (bus.pkt_done) begin
                dones++;
                got_len = bus.pkt_len;
            end
            @(posedge clock);
            if (acc) sent++;
            if (fire) rcvd++;
            if (!bus.out_ready) stall++;
        end
        chk("pkt_beats", rcvd, n);
        chk("pkt_done_cnt", dones, 32'd1);
    endtask

    task automatic idle_inputs();
        @(negedge clock);
        bus.in_valid  = 4'b0000;
        bus.in_last   = 4'b0000;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        //        vld      lst      dat           rdy      ov    od     op    ol    done  len
        vecs[0]  = '{4'b0011, 4'b0000, 32'h0000_1101, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{4'b0011, 4'b0000, 32'h0000_1101, 4'b0001, 1'b1, 8'h01, 3'd0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{4'b0011, 4'b0001, 32'h0000_1102, 4'b0001, 1'b1, 8'h02, 3'd0, 1'b1, 1'b1, 8'd2};
        vecs[3]  = '{4'b0010, 4'b0000, 32'h0000_1100, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{4'b0010, 4'b0000, 32'h0000_1100, 4'b0010, 1'b1, 8'h11, 3'd1, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{4'b0010, 4'b0010, 32'h0000_1200, 4'b0010, 1'b1, 8'h12, 3'd1, 1'b1, 1'b1, 8'd2};
        vecs[6]  = '{4'b0011, 4'b0000, 32'h0000_1303, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{4'b0011, 4'b0000, 32'h0000_1303, 4'b0001, 1'b1, 8'h03, 3'd0, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{4'b0011, 4'b0001, 32'h0000_1304, 4'b0001, 1'b1, 8'h04, 3'd0, 1'b1, 1'b1, 8'd2};
        vecs[9]  = '{4'b0010, 4'b0000, 32'h0000_1300, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'd0};
        vecs[10] = '{4'b0010, 4'b0000, 32'h0000_1300, 4'b0010, 1'b1, 8'h13, 3'd1, 1'b0, 1'b0, 8'd0};
        vecs[11] = '{4'b0010, 4'b0010, 32'h0000_1400, 4'b0010, 1'b1, 8'h14, 3'd1, 1'b1, 1'b1, 8'd2};
        vecs[12] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'd0};

        bus.policy    = 1'b0;
        bus.cfg_port  = 3'd0;
        bus.in_valid  = 4'b0000;
        bus.in_last   = 4'b0000;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b1;

        // Reset values
        #12;
        chk("rst_out_valid", bus.out_valid, 32'd0);
        chk("rst_in_ready", bus.in_ready, 32'd0);
        chk("rst_pkt_done", bus.pkt_done, 32'd0);
        chk("rst_pkt_len", bus.pkt_len, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Round-robin fairness: ports 0 and 1, two rounds of 2-beat packets
        for (int k = 0; k < 13; k++) begin
            @(negedge clock);
            bus.in_valid = vecs[k].vld;
            bus.in_last  = vecs[k].lst;
            bus.in_data  = vecs[k].dat;
            #1;
            chk($sformatf("rr%0d_rdy", k), bus.in_ready, vecs[k].rdy);
            @(posedge clock);
            #1;
            chk($sformatf("rr%0d_ov", k), bus.out_valid, vecs[k].ov);
            if (vecs[k].ov) begin
                chk($sformatf("rr%0d_od", k), bus.out_data, vecs[k].od);
                chk($sformatf("rr%0d_op", k), bus.out_port, vecs[k].op);
                chk($sformatf("rr%0d_ol", k), bus.out_last, vecs[k].ol);
            end
            chk($sformatf("rr%0d_done", k), bus.pkt_done, vecs[k].done);
            if (vecs[k].done) chk($sformatf("rr%0d_len", k), bus.pkt_len, vecs[k].len);
        end

        // Backpressure: 5 stalled cycles in the middle of a 4-beat packet
        drive_pkt(2, 4, 8'h20, 2, 5, 4'b0000, -1, len);
        chk("bp_len", len, 32'd4);
        idle_inputs();

        // Single-port lock on port 2 with port 0 also requesting
        bus.policy   = 1'b1;
        bus.cfg_port = 3'd2;
        drive_pkt(2, 3, 8'h30, 99, 0, 4'b0001, -1, len);
        chk("lock_len", len, 32'd3);
        idle_inputs();

        // Out-of-range lock port: nobody is granted
        bus.cfg_port = 3'd5;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            bus.in_valid = 4'b1111;
            bus.in_last  = 4'b1111;
            #1;
            chk("badcfg_rdy", bus.in_ready, 32'd0);
            chk("badcfg_ov", bus.out_valid, 32'd0);
        end
        idle_inputs();

        // Policy flips to single-lock mid-packet; next grant follows the lock
        bus.policy = 1'b0;
        drive_pkt(1, 4, 8'h40, 99, 0, 4'b0000, 2, len);
        chk("polchg_len", len, 32'd4);
        drive_pkt(0, 1, 8'h50, 99, 0, 4'b0100, -1, len);
        chk("single_beat_len", len, 32'd1);
        idle_inputs();

        // Length saturation on a 300-beat packet
        bus.policy = 1'b0;
        drive_pkt(3, 300, 8'h00, 999, 0, 4'b0000, -1, len);
        chk("sat_len", len, 32'd255);
        idle_inputs();

        // Reset in the middle of a packet
        bus.in_valid = 4'b0010;
        bus.in_data  = 32'h0000_6100;
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("mid_pre_ov", bus.out_valid, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_ov", bus.out_valid, 32'd0);
        chk("mid_rst_rdy", bus.in_ready, 32'd0);
        chk("mid_rst_port", bus.out_port, 32'd0);
        chk("mid_rst_data", bus.out_data, 32'd0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 4'b0000;
        reset = 1'b0;
        drive_pkt(3, 2, 8'h70, 99, 0, 4'b0000, -1, len);
        chk("post_rst_len", len, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
